// File: rtl/regfile_sb_pkg.sv
// Shared widths and helpers for the scoreboarded register file.
// Imported by regfile_sb and regfile_scoreboard.
package regfile_sb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REG_COUNT  = 32;
  localparam int DEF_ZERO_REG   = 1;
  localparam int DEF_AW         = $clog2(DEF_REG_COUNT);

  // Enough bits to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback tracker: busy bits, population count, error flag.
// Issue/write inputs arrive already filtered for writability.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int REG_COUNT = DEF_REG_COUNT,
  localparam int AW = $clog2(REG_COUNT),
  localparam int CW = cnt_width(REG_COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  output logic          rbusy1,
  output logic          rbusy2,
  output logic [CW-1:0] busy_cnt,
  output logic          wr_err
);

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nxt;
  logic [CW-1:0]        cnt_nxt;
  logic                 inc;
  logic                 dec;
  logic                 err_nxt;

  // Issue is applied after the clear so a same-address collision stays busy.
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[wa] = 1'b0;
    if (iss_valid) busy_nxt[iss_addr] = 1'b1;
    inc     = iss_valid & ~busy[iss_addr];
    dec     = we & busy[wa] & ~(iss_valid & (iss_addr == wa));
    cnt_nxt = busy_cnt + CW'(inc) - CW'(dec);
    err_nxt = we & ~busy[wa];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
      wr_err   <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      wr_err   <= err_nxt;
    end
  end

  assign rbusy1 = rst_n & busy[ra1] & ~(we & (wa == ra1));
  assign rbusy2 = rst_n & busy[ra2] & ~(we & (wa == ra2));

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with write-through bypass
// and an attached writeback scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int ZERO_REG   = DEF_ZERO_REG,
  localparam int AW = $clog2(REG_COUNT),
  localparam int CW = cnt_width(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  output logic [CW-1:0]         busy_cnt,
  output logic                  wr_err
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  wr_ok;
  logic                  iss_ok;

  assign wr_ok  = we & ((ZERO_REG == 0) | (wa != '0));
  assign iss_ok = iss_valid & ((ZERO_REG == 0) | (iss_addr != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // regs[0] is never written when hardwired, so it reads back as zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rst_n) begin
      rd1 = (wr_ok && wa == ra1) ? wd : regs[ra1];
      rd2 = (wr_ok && wa == ra2) ? wd : regs[ra2];
    end
  end

  regfile_scoreboard #(
    .REG_COUNT(REG_COUNT)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .we       (wr_ok),
    .wa       (wa),
    .iss_valid(iss_ok),
    .iss_addr (iss_addr),
    .rbusy1   (rbusy1),
    .rbusy2   (rbusy2),
    .busy_cnt (busy_cnt),
    .wr_err   (wr_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised + directed bench for regfile_sb against an array model.
// Checks combinational reads mid-cycle and registered outputs after edges.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ra1, ra2, wa, iss_addr;
  logic [DW-1:0] wd, rd1, rd2;
  logic          we, iss_valid;
  logic          rbusy1, rbusy2, wr_err;
  logic [CW-1:0] busy_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_regs [N];
  bit            m_busy [N];
  bit            m_err;
  int            cnt_before;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .rbusy1   (rbusy1),
    .rbusy2   (rbusy2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt),
    .wr_err   (wr_err)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_rd(input int a);
    if (a == 0) return '0;
    if (we && int'(wa) == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_rbusy(input int a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(we && int'(wa) == a);
  endfunction

  function automatic int m_cnt();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(m_busy[i]);
    return s;
  endfunction

  function automatic void m_step();
    int w = int'(wa);
    int s = int'(iss_addr);
    m_err = we && w != 0 && !m_busy[w];
    if (we && w != 0) begin
      m_regs[w] = wd;
      m_busy[w] = 1'b0;
    end
    if (iss_valid && s != 0) m_busy[s] = 1'b1;
  endfunction

  task automatic cyc();
    #1;
    check("rd1", rd1, m_rd(int'(ra1)));
    check("rd2", rd2, m_rd(int'(ra2)));
    check("rbusy1", rbusy1, m_rbusy(int'(ra1)));
    check("rbusy2", rbusy2, m_rbusy(int'(ra2)));
    @(posedge clk);
    m_step();
    #1;
    check("busy_cnt", busy_cnt, m_cnt());
    check("wr_err", wr_err, m_err);
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ra1 = '0; ra2 = '0; wa = '0; wd = '0;
    we = 1'b0; iss_valid = 1'b0; iss_addr = '0;
    m_clear();
    @(negedge clk);
    @(negedge clk);
    check("rst_cnt", busy_cnt, 0);
    check("rst_err", wr_err, 0);
    check("rst_rd1", rd1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bypass
    ra1 = 7; we = 1'b1; wa = 7; wd = 32'h1234_5678;
    #1 check("byp_rd1", rd1, 32'h1234_5678);
    cyc();
    idle();
    #1 check("byp_hold", rd1, 32'h1234_5678);
    cyc();

    // Scoreboard issue/writeback
    iss_valid = 1'b1; iss_addr = 3;
    cyc();
    idle(); ra1 = 3;
    #1 check("sb_busy", rbusy1, 1);
    check("sb_cnt1", busy_cnt, 1);
    we = 1'b1; wa = 3; wd = 32'hCAFE_0003;
    #1 check("sb_hide", rbusy1, 0);
    cyc();
    idle();
    check("sb_cnt0", busy_cnt, 0);
    check("sb_noerr", wr_err, 0);

    // Collision
    iss_valid = 1'b1; iss_addr = 9; we = 1'b1; wa = 9; wd = 32'hAA;
    ra1 = 9;
    cyc();
    idle();
    #1 check("col_rd", rd1, 32'hAA);
    check("col_busy", rbusy1, 1);
    check("col_cnt", busy_cnt, 1);
    we = 1'b1; wa = 9; wd = 32'hBB;
    cyc();
    idle();

    // Zero register
    cnt_before = int'(busy_cnt);
    ra1 = 0; ra2 = 0;
    we = 1'b1; wa = 0; wd = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_addr = 0;
    #1 check("z_rd", rd1, 0);
    check("z_busy", rbusy1, 0);
    cyc();
    idle();
    check("z_cnt", busy_cnt, cnt_before);
    check("z_err", wr_err, 0);
    #1 check("z_rd_after", rd2, 0);

    // Full scoreboard
    for (int i = 1; i < N; i++) begin
      iss_valid = 1'b1; iss_addr = AW'(i);
      cyc();
    end
    idle();
    check("full_cnt", busy_cnt, 31);
    we = 1'b1; wa = 4; wd = 32'h44;
    cyc();
    check("full_ok", wr_err, 0);
    we = 1'b1; wa = 4; wd = 32'h45;
    cyc();
    idle();
    check("full_err", wr_err, 1);
    cyc();
    check("full_pulse", wr_err, 0);

    // Reset mid-operation
    we = 1'b1; wa = 5; wd = 32'hDEAD_BEEF; ra1 = 5;
    cyc();
    idle();
    #1 check("pre_rst", rd1, 32'hDEAD_BEEF);
    we = 1'b1; wa = 5; wd = 32'h1;
    rst_n = 1'b0;
    #1 check("rst_rd1", rd1, 0);
    check("rst_cnt", busy_cnt, 0);
    check("rst_rbusy", rbusy1, 0);
    m_clear();
    @(posedge clk);
    #1 check("rst_hold", rd1, 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    cyc();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      we        = 1'($urandom_range(0, 1));
      wa        = AW'($urandom_range(0, N - 1));
      wd        = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = ($urandom_range(0, 5) == 0) ? wa
                : AW'($urandom_range(0, N - 1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, N - 1));
      ra2 = ($urandom_range(0, 3) == 0) ? iss_addr
          : AW'($urandom_range(0, N - 1));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
